// File: rtl/flex_pts_pkg.sv
// Shared types and constants for the flex_pts_tx parallel-to-serial transmitter.
//   pts_state_t     : FSM state encoding (PTS_PARITY only reachable with FLEX_PTS_PARITY_EN)
//   PTS_IDLE_LEVEL  : level driven on the serial line when no frame is in flight
package flex_pts_pkg;

  typedef enum logic [1:0] {
    PTS_IDLE,
    PTS_SHIFT,
    PTS_PARITY
  } pts_state_t;

  localparam logic PTS_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/flex_pts_if.sv
// Word handshake between the packet/byte logic and flex_pts_tx.
//   tx_data  : word to transmit, sampled on accept
//   tx_valid : tx_data valid
//   tx_ready : transmitter can accept a word this cycle
// master = word source, slave = transmitter.
interface flex_pts_if #(
  parameter int unsigned NUM_BITS = 8
);
  logic [NUM_BITS-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/pts_bit_counter.sv
// Saturating bit counter for the transmitter's shift phase.
//   clk, rst         : clock, asynchronous active-high reset
//   clear_i          : synchronous clear to 0 (has priority)
//   count_enable_i   : increment by one, stops at MAX (no wrap)
//   count_o          : current count, width $clog2(MAX+2)
//   at_max_o         : count_o == MAX
module pts_bit_counter #(
  parameter int unsigned MAX = 7,
  localparam int unsigned CntW = $clog2(MAX + 2)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            count_enable_i,
  output logic [CntW-1:0] count_o,
  output logic            at_max_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign at_max_o = (cnt_q == CntW'(MAX));
  assign count_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_enable_i && !at_max_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/flex_pts_tx.sv
// Parallel-to-serial transmitter. Accepts a NUM_BITS word over a valid/ready handshake and
// shifts it out one bit per shift_enable_i strobe; the line idles high.
//   clk, rst        : clock, asynchronous active-high reset (aborts any frame in flight)
//   shift_enable_i  : bit-rate strobe, one pulse per bit period
//   tx_io           : word handshake (slave side)
//   serial_out_o    : serial line, idle = 1
//   busy_o          : frame in progress
//   tx_done_o       : one-cycle pulse in the first idle cycle after the last bit period
// Build option: define FLEX_PTS_PARITY_EN to append an even-parity bit after the data bits.
module flex_pts_tx
  import flex_pts_pkg::*;
#(
  parameter int unsigned NUM_BITS  = 8,
  parameter bit          SHIFT_MSB = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_enable_i,
  flex_pts_if.slave  tx_io,
  output logic       serial_out_o,
  output logic       busy_o,
  output logic       tx_done_o
);

  localparam int unsigned CntW = $clog2(NUM_BITS + 1);

  pts_state_t          state_q, state_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic                done_q, done_d;
  logic                load, shift, last_bit;
  logic [CntW-1:0]     bit_cnt;

  pts_bit_counter #(
    .MAX (NUM_BITS - 1)
  ) u_bit_counter (
    .clk            (clk),
    .rst            (rst),
    .clear_i        (load),
    .count_enable_i (shift),
    .count_o        (bit_cnt),
    .at_max_o       (last_bit)
  );

  // Strobes only count in SHIFT/PARITY; a strobe in the accept cycle falls in IDLE and is dropped.
  always_comb begin
    state_d        = state_q;
    load           = 1'b0;
    shift          = 1'b0;
    done_d         = 1'b0;
    tx_io.tx_ready = 1'b0;
    busy_o         = 1'b1;
    unique case (state_q)
      PTS_IDLE: begin
        tx_io.tx_ready = 1'b1;
        busy_o         = 1'b0;
        if (tx_io.tx_valid) begin
          load    = 1'b1;
          state_d = PTS_SHIFT;
        end
      end
      PTS_SHIFT: begin
        if (shift_enable_i) begin
          shift = 1'b1;
          if (last_bit) begin
`ifdef FLEX_PTS_PARITY_EN
            state_d = PTS_PARITY;
`else
            state_d = PTS_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end
`ifdef FLEX_PTS_PARITY_EN
      PTS_PARITY: begin
        if (shift_enable_i) begin
          state_d = PTS_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = PTS_IDLE;
    endcase
  end

  // Shift toward the output end and back-fill with the idle level, so the register is all
  // ones again by the time the frame finishes.
  always_comb begin
    shift_d = shift_q;
    if (load) begin
      shift_d = tx_io.tx_data;
    end else if (shift) begin
      if (SHIFT_MSB) begin
        shift_d = {shift_q[NUM_BITS-2:0], PTS_IDLE_LEVEL};
      end else begin
        shift_d = {PTS_IDLE_LEVEL, shift_q[NUM_BITS-1:1]};
      end
    end
  end

`ifdef FLEX_PTS_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (load) begin
      parity_q <= ^tx_io.tx_data;
    end
  end
`endif

  // Decoded from state so an asynchronous reset forces the idle level immediately.
  always_comb begin
    serial_out_o = PTS_IDLE_LEVEL;
    if (state_q == PTS_SHIFT) begin
      serial_out_o = SHIFT_MSB ? shift_q[NUM_BITS-1] : shift_q[0];
    end
`ifdef FLEX_PTS_PARITY_EN
    if (state_q == PTS_PARITY) begin
      serial_out_o = parity_q;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= PTS_IDLE;
      shift_q <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

  assign tx_done_o = done_q;

  bit_cnt_in_range_a : assert property (@(posedge clk) disable iff (rst)
    (state_q == PTS_SHIFT) |-> (bit_cnt <= CntW'(NUM_BITS - 1)));

endmodule

// File: tb/tb_flex_pts_tx.sv
// Self-checking bench for flex_pts_tx: one MSB-first and one LSB-first instance, with a
// per-instance scoreboard of expected line bits filled on accept and drained on strobes.
module tb_flex_pts_tx;

`ifdef FLEX_PTS_PARITY_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif
  localparam int FrameLen = ParEn ? 9 : 8;

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic se0, se1;
  logic so0, so1, busy0, busy1, done0, done1;

  flex_pts_if #(.NUM_BITS(8)) if0 ();
  flex_pts_if #(.NUM_BITS(8)) if1 ();

  flex_pts_tx #(
    .NUM_BITS  (8),
    .SHIFT_MSB (1'b1)
  ) u_dut_msb (
    .clk            (clk),
    .rst            (rst),
    .shift_enable_i (se0),
    .tx_io          (if0.slave),
    .serial_out_o   (so0),
    .busy_o         (busy0),
    .tx_done_o      (done0)
  );

  flex_pts_tx #(
    .NUM_BITS  (8),
    .SHIFT_MSB (1'b0)
  ) u_dut_lsb (
    .clk            (clk),
    .rst            (rst),
    .shift_enable_i (se1),
    .tx_io          (if1.slave),
    .serial_out_o   (so1),
    .busy_o         (busy1),
    .tx_done_o      (done1)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  bit   m_busy[2];
  bit   m_done[2];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Instance 0 sends MSB first, instance 1 LSB first.
  task automatic push_frame(input int d, input logic [7:0] data);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.b    = (d == 0) ? data[7-i] : data[i];
      e.last = (i == 7) && !ParEn;
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
    if (ParEn) begin
      e.b    = ^data;
      e.last = 1'b1;
      if (d == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
  endtask

  // Compare one instance against the model for this cycle, then advance the model to
  // what the coming posedge should do.
  task automatic mon(input int d, input logic rdy, input logic bsy, input logic dn,
                     input logic ser, input logic vld, input logic se, input logic [7:0] data);
    exp_t head;
    int   sz;
    logic exp_ser;
    bit   nb, nd;
    if (rst) begin
      if (d == 0) sb0.delete();
      else        sb1.delete();
      m_busy[d] = 1'b0;
      m_done[d] = 1'b0;
    end
    sz   = (d == 0) ? sb0.size() : sb1.size();
    head = '0;
    if (sz > 0) head = (d == 0) ? sb0[0] : sb1[0];
    exp_ser = (m_busy[d] && sz > 0) ? head.b : 1'b1;
    chk($sformatf("ready%0d", d), {31'b0, rdy}, {31'b0, !m_busy[d]});
    chk($sformatf("busy%0d", d), {31'b0, bsy}, {31'b0, m_busy[d]});
    chk($sformatf("done%0d", d), {31'b0, dn}, {31'b0, m_done[d]});
    chk($sformatf("serial%0d", d), {31'b0, ser}, {31'b0, exp_ser});
    nb = m_busy[d];
    nd = 1'b0;
    if (!rst) begin
      if (!m_busy[d]) begin
        if (vld) begin
          push_frame(d, data);
          nb = 1'b1;
        end
      end else if (se && sz > 0) begin
        if (d == 0) void'(sb0.pop_front());
        else        void'(sb1.pop_front());
        if (head.last) begin
          nb = 1'b0;
          nd = 1'b1;
        end
      end
    end
    m_busy[d] = nb;
    m_done[d] = nd;
  endtask

  always @(negedge clk) begin
    mon(0, if0.tx_ready, busy0, done0, so0, if0.tx_valid, se0, if0.tx_data);
    mon(1, if1.tx_ready, busy1, done1, so1, if1.tx_valid, se1, if1.tx_data);
  end

  task automatic set_se(input int d, input logic v);
    if (d == 0) se0 = v;
    else        se1 = v;
  endtask

  task automatic strobe(input int d, input int n, input int gap);
    repeat (n) begin
      set_se(d, 1'b1);
      @(posedge clk); #1;
      set_se(d, 1'b0);
      repeat (gap - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic send0(input logic [7:0] data);
    if0.tx_data  = data;
    if0.tx_valid = 1'b1;
    @(posedge clk); #1;
    if0.tx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst          = 1'b1;
    se0          = 1'b0;
    se1          = 1'b0;
    if0.tx_valid = 1'b0;
    if0.tx_data  = '0;
    if1.tx_valid = 1'b0;
    if1.tx_data  = '0;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Reset in the middle of a frame: outputs go idle in the same cycle.
    send0(8'hA5);
    strobe(0, 2, 2);
    rst = 1'b1;
    #1;
    chk("rst_serial", {31'b0, so0}, 32'd1);
    chk("rst_busy", {31'b0, busy0}, 32'd0);
    chk("rst_ready", {31'b0, if0.tx_ready}, 32'd1);
    chk("rst_done", {31'b0, done0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);

    // MSB first, 0xA5, strobe every 4 clk.
    send0(8'hA5);
    strobe(0, FrameLen, 4);
    idle(3);

    // LSB first, 0x01: idle strobes, a strobe in the accept cycle, then one strobe per clk.
    se1 = 1'b1;
    idle(3);
    if1.tx_data  = 8'h01;
    if1.tx_valid = 1'b1;
    idle(1);
    if1.tx_valid = 1'b0;
    idle(FrameLen);
    se1 = 1'b0;
    idle(3);

    // Back-to-back with tx_valid held; tx_data wiggles mid-frame.
    if0.tx_data  = 8'hFF;
    if0.tx_valid = 1'b1;
    idle(1);
    if0.tx_data = 8'h3C;
    strobe(0, FrameLen - 1, 2);
    if0.tx_data = 8'h00;
    strobe(0, 1, 2);
    if0.tx_valid = 1'b0;
    if0.tx_data  = 8'hC3;
    strobe(0, FrameLen, 1);
    idle(3);

    // 0x07: three ones, so the parity bit (when built in) is 1.
    send0(8'h07);
    strobe(0, FrameLen, 3);
    idle(4);

    chk("sb0_drained", sb0.size(), 32'd0);
    chk("sb1_drained", sb1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
